// File: rtl/spm_boot_loader_if.sv
// Load/memory-write bundle between the host loader, spm_boot_loader and the core's word memory.
interface spm_boot_loader_if #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [WORD_SIZE-1:0]  ld_data;
  logic                  ld_last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_wdata;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last,
    input  ld_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last,
    output ld_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/spm_boot_loader.sv
// Boot sequencer for RISC_SPM: memory flush, program load, run supervision with HALT detect.
// Define SPM_BOOT_WDOG_EN to enable the run watchdog (TIMEOUT); otherwise RUN ends only on HALT or rst.
module spm_boot_loader #(
  parameter int         WORD_SIZE   = 8,
  parameter int         ADDR_WIDTH  = 8,
  parameter logic [3:0] HALT_OPCODE = 4'b1111,
  parameter int         WDOG_CYCLES = 3000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  spm_boot_loader_if.slave     bus,
  input  logic [WORD_SIZE-1:0] instr,
  output logic                 core_rst_n,
  output logic                 busy,
  output logic                 halted,
  output logic                 timeout,
  output logic [15:0]          cycle_count
);

  typedef enum logic [2:0] {IDLE, FLUSH, LOAD, SETTLE, RUN, HALTED, TIMEOUT} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [15:0]           WDOG_LAST = 16'(WDOG_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  ld_ready_q, ld_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic                  timeout_q, timeout_d;
  logic [15:0]           cnt_q, cnt_d;

  logic ld_fire, is_halt, wdog_hit;

  assign ld_fire = bus.ld_valid & ld_ready_q;
  assign is_halt = (instr[WORD_SIZE-1 -: 4] == HALT_OPCODE);

`ifdef SPM_BOOT_WDOG_EN
  assign wdog_hit = (cnt_q >= WDOG_LAST);
`else
  assign wdog_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED, TIMEOUT: if (start) state_d = FLUSH;
      FLUSH:  if (mem_addr_q == LAST_ADDR) state_d = LOAD;
      LOAD:   if (ld_fire && bus.ld_last) state_d = SETTLE;
      // first SETTLE cycle still carries the last load write; the second is the quiet one
      SETTLE: if (!mem_we_q) state_d = RUN;
      RUN: begin
        if (is_halt)       state_d = HALTED;
        else if (wdog_hit) state_d = TIMEOUT;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs, computed one cycle ahead so every port is a flop
  always_comb begin
    ld_ready_d   = (state_d == LOAD);
    busy_d       = (state_d == FLUSH) || (state_d == LOAD) || (state_d == SETTLE) || (state_d == RUN);
    core_rst_n_d = (state_d == RUN);
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE, HALTED, TIMEOUT: begin
        if (start) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          halted_d    = 1'b0;
          timeout_d   = 1'b0;
          cnt_d       = '0;
        end
      end
      FLUSH: begin
        if (mem_addr_q != LAST_ADDR) begin
          mem_we_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      LOAD: begin
        if (ld_fire) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.ld_addr;
          mem_wdata_d = bus.ld_data;
        end
      end
      RUN: begin
        if (is_halt)               halted_d  = 1'b1;
        else if (wdog_hit)         timeout_d = 1'b1;
        else if (cnt_q != 16'hFFFF) cnt_d    = cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ld_ready_q   <= ld_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.ld_ready  = ld_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rst_n    = core_rst_n_q;
  assign busy          = busy_q;
  assign halted        = halted_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cnt_q;

endmodule
